// File: rtl/insn_queue_pkg.sv
// Shared types and constants for the fetch-to-decode instruction queue.
// Entry layout carries the instruction word plus its branch-prediction sidecar.
package insn_queue_pkg;

  localparam int M_WIDTH          = 32;
  localparam int LG_PHT_SZ        = 16;
  localparam int LG_DEPTH_DEFAULT = 3;

  typedef struct packed {
    logic [31:0]          insn;
    logic [M_WIDTH-1:0]   pc;
    logic                 pred;
    logic [LG_PHT_SZ-1:0] pht_idx;
    logic [M_WIDTH-1:0]   pred_target;
  } insn_q_entry_t;

  localparam int ENTRY_W = 32 + 2 * M_WIDTH + 1 + LG_PHT_SZ;

endpackage

// File: rtl/insn_queue_if.sv
// Fetch-side and decode-side handshake bundle for insn_queue.
// Handshake: a transfer happens on a clock edge where valid && ready; valid must not depend on ready.
interface insn_queue_if;
  import insn_queue_pkg::*;

  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_insn;
  logic [M_WIDTH-1:0]   in_pc;
  logic                 in_pred;
  logic [LG_PHT_SZ-1:0] in_pht_idx;
  logic [M_WIDTH-1:0]   in_pred_target;

  logic                 out_valid;
  logic                 out_ready;
  logic [31:0]          out_insn;
  logic [M_WIDTH-1:0]   out_pc;
  logic                 out_pred;
  logic [LG_PHT_SZ-1:0] out_pht_idx;
  logic [M_WIDTH-1:0]   out_pred_target;

  // master: fetch producer plus decode consumer; slave: the queue itself
  modport master (
    output in_valid, in_insn, in_pc, in_pred, in_pht_idx, in_pred_target,
    input  in_ready,
    input  out_valid, out_insn, out_pc, out_pred, out_pht_idx, out_pred_target,
    output out_ready
  );

  modport slave (
    input  in_valid, in_insn, in_pc, in_pred, in_pht_idx, in_pred_target,
    output in_ready,
    output out_valid, out_insn, out_pc, out_pred, out_pht_idx, out_pred_target,
    input  out_ready
  );

endinterface

// File: rtl/insn_queue_ram.sv
// Flop storage for the instruction queue: one synchronous write port, one asynchronous read port.
// Contents are intentionally not reset; validity is tracked by the pointers in insn_queue.
module insn_queue_ram
  import insn_queue_pkg::*;
#(
  parameter int LG_DEPTH = LG_DEPTH_DEFAULT
) (
  input  logic                clk,
  input  logic                we,
  input  logic [LG_DEPTH-1:0] waddr,
  input  insn_q_entry_t       wdata,
  input  logic [LG_DEPTH-1:0] raddr,
  output insn_q_entry_t       rdata
);

  insn_q_entry_t mem [2**LG_DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/insn_queue.sv
// Fetch-to-decode instruction buffer with one-cycle flush and registered-only in_ready.
// Optional same-cycle empty-queue bypass is enabled by defining INSN_QUEUE_BYPASS_EN.
module insn_queue
  import insn_queue_pkg::*;
#(
  parameter int LG_DEPTH = LG_DEPTH_DEFAULT
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  insn_queue_if.slave       q,
  output logic [LG_DEPTH:0] occupancy
);

  logic [LG_DEPTH:0] head;
  logic [LG_DEPTH:0] tail;
  logic              empty;
  logic              full;
  logic              push;
  logic              pop;
  logic              out_valid;
  insn_q_entry_t     in_entry;
  insn_q_entry_t     ram_rdata;
  insn_q_entry_t     out_entry;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (head == tail);
  assign full  = (head[LG_DEPTH] != tail[LG_DEPTH]) &&
                 (head[LG_DEPTH-1:0] == tail[LG_DEPTH-1:0]);

  assign in_entry = {q.in_insn, q.in_pc, q.in_pred, q.in_pht_idx, q.in_pred_target};

  always_comb begin
    out_entry = ram_rdata;
    out_valid = !empty;
    push      = q.in_valid && !full && !flush;
    pop       = !empty && q.out_ready && !flush;
`ifdef INSN_QUEUE_BYPASS_EN
    // Empty queue forwards the fetch entry; a consumed forward never touches storage.
    if (empty && !flush && q.in_valid) begin
      out_valid = 1'b1;
      out_entry = in_entry;
      if (q.out_ready) begin
        push = 1'b0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head <= '0;
      tail <= '0;
    end else if (flush) begin
      head <= '0;
      tail <= '0;
    end else begin
      if (push) begin
        tail <= tail + 1'b1;
      end
      if (pop) begin
        head <= head + 1'b1;
      end
    end
  end

  insn_queue_ram #(
    .LG_DEPTH (LG_DEPTH)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (tail[LG_DEPTH-1:0]),
    .wdata (in_entry),
    .raddr (head[LG_DEPTH-1:0]),
    .rdata (ram_rdata)
  );

  assign q.in_ready        = !full;
  assign q.out_valid       = out_valid;
  assign q.out_insn        = out_entry.insn;
  assign q.out_pc          = out_entry.pc;
  assign q.out_pred        = out_entry.pred;
  assign q.out_pht_idx     = out_entry.pht_idx;
  assign q.out_pred_target = out_entry.pred_target;

  assign occupancy = tail - head;

endmodule

// File: tb/tb_insn_queue.sv
// Self-checking bench for insn_queue: reset, latency, fill/drain, wrap, flush, sidecar, random traffic.
// Bypass scenario is included only when INSN_QUEUE_BYPASS_EN is defined.
module tb_insn_queue;
  import insn_queue_pkg::*;

  localparam int LG    = LG_DEPTH_DEFAULT;
  localparam int DEPTH = 1 << LG;
`ifdef INSN_QUEUE_BYPASS_EN
  localparam int STREAM_OCC = 0;
`else
  localparam int STREAM_OCC = 1;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic [LG:0] occupancy;

  insn_queue_if q_if ();

  insn_queue #(.LG_DEPTH(LG)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .flush     (flush),
    .q         (q_if),
    .occupancy (occupancy)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  bit mon_en   = 1'b0;

  logic [ENTRY_W-1:0] exp_q[$];
  logic [ENTRY_W-1:0] mon_exp;
  logic               mon_valid;
  logic               mon_ready;

  function automatic logic [ENTRY_W-1:0] in_vec();
    return {q_if.in_insn, q_if.in_pc, q_if.in_pred, q_if.in_pht_idx, q_if.in_pred_target};
  endfunction

  function automatic logic [ENTRY_W-1:0] out_vec();
    return {q_if.out_insn, q_if.out_pc, q_if.out_pred, q_if.out_pht_idx, q_if.out_pred_target};
  endfunction

  // scoreboard: decides what the next edge will do from its own model, then checks the DUT
  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      mon_ready = (exp_q.size() < DEPTH);
      mon_valid = (exp_q.size() != 0);
`ifdef INSN_QUEUE_BYPASS_EN
      if (exp_q.size() == 0 && q_if.in_valid && !flush) mon_valid = 1'b1;
`endif
      n_checks++;
      if (q_if.in_ready !== mon_ready) begin
        n_fail++;
        $display("FAIL sb_in_ready: got %b expected %b", q_if.in_ready, mon_ready);
      end
      n_checks++;
      if (q_if.out_valid !== mon_valid) begin
        n_fail++;
        $display("FAIL sb_out_valid: got %b expected %b", q_if.out_valid, mon_valid);
      end
      n_checks++;
      if (occupancy !== exp_q.size()) begin
        n_fail++;
        $display("FAIL sb_occupancy: got %0d expected %0d", occupancy, exp_q.size());
      end
      if (flush) begin
        exp_q.delete();
      end else begin
        if (q_if.in_valid && mon_ready) exp_q.push_back(in_vec());
        if (mon_valid && q_if.out_ready) begin
          mon_exp = exp_q.pop_front();
          n_checks++;
          if (out_vec() !== mon_exp) begin
            n_fail++;
            $display("FAIL sb_data: got %h expected %h", out_vec(), mon_exp);
          end
        end
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_in(input logic [31:0] insn, input logic [M_WIDTH-1:0] pc,
                        input logic pred, input logic [LG_PHT_SZ-1:0] pht,
                        input logic [M_WIDTH-1:0] tgt);
    q_if.in_valid       = 1'b1;
    q_if.in_insn        = insn;
    q_if.in_pc          = pc;
    q_if.in_pred        = pred;
    q_if.in_pht_idx     = pht;
    q_if.in_pred_target = tgt;
  endtask

  task automatic test_reset();
    mon_en              = 1'b0;
    reset_n             = 1'b0;
    flush               = 1'b0;
    q_if.in_valid       = 1'b0;
    q_if.out_ready      = 1'b0;
    q_if.in_insn        = '0;
    q_if.in_pc          = '0;
    q_if.in_pred        = 1'b0;
    q_if.in_pht_idx     = '0;
    q_if.in_pred_target = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (q_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", q_if.out_valid); end
    n_checks++;
    if (occupancy !== 0) begin n_fail++; $display("FAIL reset_occupancy: got %0d expected 0", occupancy); end
    n_checks++;
    if (q_if.in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", q_if.in_ready); end
    step();
    reset_n = 1'b1;
    mon_en  = 1'b1;
  endtask

  task automatic test_single_push();
    q_if.out_ready = 1'b0;
    set_in(32'h00500093, 32'h1000, 1'b0, '0, '0);
    step();
    q_if.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (q_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid: got %b expected 1", q_if.out_valid); end
    n_checks++;
    if (q_if.out_insn !== 32'h00500093) begin n_fail++; $display("FAIL single_insn: got %h expected 00500093", q_if.out_insn); end
    n_checks++;
    if (q_if.out_pc !== 32'h1000) begin n_fail++; $display("FAIL single_pc: got %h expected 1000", q_if.out_pc); end
    n_checks++;
    if (occupancy !== 1) begin n_fail++; $display("FAIL single_occupancy: got %0d expected 1", occupancy); end
    step();
    q_if.out_ready = 1'b1;
    step();
    q_if.out_ready = 1'b0;
  endtask

  task automatic test_fill_drain();
    q_if.out_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      set_in($urandom, 32'(i * 4), 1'b0, 16'($urandom), $urandom);
      step();
    end
    set_in(32'hdeadbeef, 32'h20, 1'b0, '0, '0);
    @(negedge clk);
    n_checks++;
    if (q_if.in_ready !== 1'b0) begin n_fail++; $display("FAIL full_in_ready: got %b expected 0", q_if.in_ready); end
    n_checks++;
    if (occupancy !== DEPTH) begin n_fail++; $display("FAIL full_occupancy: got %0d expected %0d", occupancy, DEPTH); end
    step();
    q_if.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (occupancy !== DEPTH) begin n_fail++; $display("FAIL ninth_rejected: got %0d expected %0d", occupancy, DEPTH); end
    step();
    q_if.out_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      n_checks++;
      if (q_if.out_pc !== 32'(i * 4)) begin n_fail++; $display("FAIL drain_pc: got %h expected %h", q_if.out_pc, 32'(i * 4)); end
      step();
    end
    q_if.out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (q_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL drain_empty: got %b expected 0", q_if.out_valid); end
    step();
  endtask

  task automatic test_back_to_back();
    q_if.out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_in($urandom, 32'(32'h100 + i * 4), 1'b0, 16'($urandom), $urandom);
      @(negedge clk);
      if (i > 0) begin
        n_checks++;
        if (occupancy !== STREAM_OCC) begin n_fail++; $display("FAIL stream_occupancy: got %0d expected %0d", occupancy, STREAM_OCC); end
      end
      step();
    end
    q_if.in_valid = 1'b0;
    step();
    q_if.out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (occupancy !== 0) begin n_fail++; $display("FAIL stream_drained: got %0d expected 0", occupancy); end
    step();
  endtask

  task automatic test_flush();
    q_if.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_in($urandom, 32'(32'h1800 + i * 4), 1'b0, '0, '0);
      step();
    end
    set_in(32'h00000013, 32'h2000, 1'b0, '0, '0);
    flush = 1'b1;
    step();
    flush = 1'b0;
    q_if.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (q_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL flush_out_valid: got %b expected 0", q_if.out_valid); end
    n_checks++;
    if (occupancy !== 0) begin n_fail++; $display("FAIL flush_occupancy: got %0d expected 0", occupancy); end
    step();
    set_in(32'h00100113, 32'h2004, 1'b0, '0, '0);
    step();
    q_if.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (q_if.out_pc !== 32'h2004) begin n_fail++; $display("FAIL flush_discard: got %h expected 2004", q_if.out_pc); end
    q_if.out_ready = 1'b1;
    step();
    q_if.out_ready = 1'b0;
  endtask

  task automatic test_sidecar();
    q_if.out_ready = 1'b0;
    set_in(32'h00a00063, 32'h3ffc, 1'b1, 16'h2a, 32'h4000);
    step();
    q_if.in_valid = 1'b0;
    @(negedge clk);
    n_checks++;
    if (q_if.out_pred !== 1'b1) begin n_fail++; $display("FAIL sidecar_pred: got %b expected 1", q_if.out_pred); end
    n_checks++;
    if (q_if.out_pht_idx !== 16'h2a) begin n_fail++; $display("FAIL sidecar_pht: got %h expected 2a", q_if.out_pht_idx); end
    n_checks++;
    if (q_if.out_pred_target !== 32'h4000) begin n_fail++; $display("FAIL sidecar_target: got %h expected 4000", q_if.out_pred_target); end
    q_if.out_ready = 1'b1;
    step();
    q_if.out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      q_if.in_valid       = 1'($urandom_range(0, 1));
      q_if.in_insn        = $urandom;
      q_if.in_pc          = $urandom;
      q_if.in_pred        = 1'($urandom_range(0, 1));
      q_if.in_pht_idx     = 16'($urandom);
      q_if.in_pred_target = $urandom;
      q_if.out_ready      = (i < 150) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      step();
    end
    q_if.in_valid  = 1'b0;
    q_if.out_ready = 1'b1;
    repeat (DEPTH + 1) step();
    q_if.out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (q_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL random_drained: got %b expected 0", q_if.out_valid); end
    step();
  endtask

  task automatic test_async_reset();
    q_if.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_in($urandom, 32'(32'h5000 + i * 4), 1'b0, '0, '0);
      step();
    end
    q_if.in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    exp_q.delete();
    #1;
    n_checks++;
    if (q_if.out_valid !== 1'b0) begin n_fail++; $display("FAIL areset_out_valid: got %b expected 0", q_if.out_valid); end
    n_checks++;
    if (occupancy !== 0) begin n_fail++; $display("FAIL areset_occupancy: got %0d expected 0", occupancy); end
    step();
    reset_n = 1'b1;
    step();
  endtask

`ifdef INSN_QUEUE_BYPASS_EN
  task automatic test_bypass();
    q_if.out_ready = 1'b1;
    set_in(32'h00000093, 32'h3000, 1'b0, '0, '0);
    #1;
    n_checks++;
    if (q_if.out_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_valid: got %b expected 1", q_if.out_valid); end
    n_checks++;
    if (q_if.out_pc !== 32'h3000) begin n_fail++; $display("FAIL bypass_pc: got %h expected 3000", q_if.out_pc); end
    step();
    q_if.in_valid  = 1'b0;
    q_if.out_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (occupancy !== 0) begin n_fail++; $display("FAIL bypass_occupancy: got %0d expected 0", occupancy); end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single_push();
    test_fill_drain();
    test_back_to_back();
    test_flush();
    test_sidecar();
`ifdef INSN_QUEUE_BYPASS_EN
    test_bypass();
`endif
    test_random();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
